// File: rtl/layer_sequencer.sv
// Layer sequencer: steps the layer stages through clear, run and drain phases,
// with a start/busy/done handshake toward the host and a per-stage watchdog.
module layer_sequencer #(
  parameter int NUM_LAYERS   = 3,
  parameter int DRAIN_CYCLES = 2,
  parameter int TIMEOUT      = 1024,
  parameter int IDX_W        = $clog2(NUM_LAYERS) + (NUM_LAYERS == 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] layer_valid,
  output logic [NUM_LAYERS-1:0] layer_clear,
  output logic [NUM_LAYERS-1:0] layer_enable,
  output logic [IDX_W-1:0]      layer_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [DW-1:0] DLAST =
    DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] ILAST = IDX_W'(NUM_LAYERS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  logic [2:0]       state;
  logic [IDX_W-1:0] idx;
  logic [DW-1:0]    drain;
  logic [WW-1:0]    wdog;

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state <= S_IDLE;
      idx   <= '0;
      drain <= '0;
      wdog  <= '0;
    end else begin
      case (state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            state <= S_CLEAR;
            idx   <= '0;
            drain <= '0;
            wdog  <= '0;
          end
        end
        S_CLEAR: state <= S_RUN;
        S_RUN: begin
          wdog <= wdog + 1'b1;
          if (layer_valid[idx])
            state <= (DRAIN_CYCLES > 0) ? S_DRAIN : S_NEXT;
          else if (wdog == WLAST)
            state <= S_ERROR;
        end
        S_DRAIN: begin
          drain <= drain + 1'b1;
          if (drain == DLAST)
            state <= S_NEXT;
        end
        S_NEXT: begin
          if (idx == ILAST) begin
            state <= S_DONE;
          end else begin
            state <= S_CLEAR;
            idx   <= idx + 1'b1;
            drain <= '0;
            wdog  <= '0;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // outputs decode straight from the state/idx registers
  always_comb begin
    layer_clear  = '0;
    layer_enable = '0;
    if (state == S_CLEAR)
      layer_clear[idx] = 1'b1;
    if (state == S_RUN || state == S_DRAIN)
      layer_enable[idx] = 1'b1;
  end

  assign layer_idx = idx;
  assign busy  = (state == S_CLEAR) || (state == S_RUN) ||
                 (state == S_DRAIN) || (state == S_NEXT);
  assign done  = (state == S_DONE);
  assign error = (state == S_ERROR);

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: behavioural stage models, expected clear/done/error
// events queued by the stimulus and checked by an independent monitor.
module tb_layer_sequencer;

  localparam int NL  = 3;
  localparam int DRN = 2;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [NL-1:0] layer_valid;
  logic [NL-1:0] layer_clear;
  logic [NL-1:0] layer_enable;
  logic [1:0]    layer_idx;
  logic          busy;
  logic          done;
  logic          error;

  layer_sequencer #(
    .NUM_LAYERS(NL),
    .DRAIN_CYCLES(DRN),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .layer_valid(layer_valid),
    .layer_clear(layer_clear),
    .layer_enable(layer_enable),
    .layer_idx(layer_idx),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int kind;
    int val;
    int at;
  } ev_t;

  ev_t exp_q[$];

  int            dly[NL];
  int            cnt[NL];
  logic [NL-1:0] force_v;
  logic          err_d = 1'b0;

  // stage model: valid rises once enable has been seen dly[i] cycles
  always @(negedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (layer_clear[i])
        cnt[i] = 0;
      else if (layer_enable[i])
        cnt[i] = cnt[i] + 1;
      layer_valid[i] = force_v[i] |
        (layer_enable[i] & (cnt[i] >= dly[i]));
    end
  end

  function automatic int idx_of(input logic [NL-1:0] v);
    for (int i = 0; i < NL; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk_ev(input int k, input int v);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event kind=%0d val=%0d cyc=%0d",
               k, v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v || e.at != cyc) begin
        bad++;
        $display("FAIL event got kind=%0d val=%0d cyc=%0d exp kind=%0d val=%0d cyc=%0d",
                 k, v, cyc, e.kind, e.val, e.at);
      end
    end
  endtask

  // monitor: kind 0=clear, 1=done, 2=error rise
  always @(negedge clk) begin
    if (!reset) begin
      if (|layer_clear) chk_ev(0, idx_of(layer_clear));
      if (done) chk_ev(1, int'(layer_idx));
      if (error && !err_d) chk_ev(2, int'(layer_idx));
      total++;
      if (!$onehot0(layer_clear | layer_enable) ||
          ((|layer_clear) && (|layer_enable))) begin
        bad++;
        $display("FAIL onehot clear=%b enable=%b cyc=%0d",
                 layer_clear, layer_enable, cyc);
      end
      total++;
      if (error && (|layer_enable)) begin
        bad++;
        $display("FAIL err_enable enable=%b cyc=%0d", layer_enable, cyc);
      end
      total++;
      if (((|(layer_clear | layer_enable)) && !busy) || (done && busy)) begin
        bad++;
        $display("FAIL busy_rel busy=%b done=%b cyc=%0d", busy, done, cyc);
      end
    end
    err_d = error;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) tick(1);
  endtask

  task automatic push(input int k, input int v, input int at);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", nm, got, exp, cyc);
    end
  endtask

  task automatic q_empty(input string nm);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s pending=%0d exp=0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({layer_clear, layer_enable, layer_idx, busy, done, error});
  endfunction

  // full three-stage run; returns clear0 cycle and done cycle
  task automatic run3(input int d0, input int d1, input int d2,
                      output int ts, output int td);
    int c1, c2;
    dly[0] = d0;
    dly[1] = d1;
    dly[2] = d2;
    ts = cyc + 1;
    c1 = ts + d0 + DRN + 2;
    c2 = c1 + d1 + DRN + 2;
    td = c2 + d2 + DRN + 2;
    push(0, 0, ts);
    push(0, 1, c1);
    push(0, 2, c2);
    push(1, 2, td);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  int ts, td, c1;

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    force_v = '0;
    for (int i = 0; i < NL; i++) dly[i] = 1000;
    tick(3);
    chk("reset_outs", outs(), 32'd0);
    reset = 1'b0;
    tick(2);
    chk("idle_outs", outs(), 32'd0);

    // nominal run, equal stage latencies
    run3(17, 17, 17, ts, td);
    chk("t1_clear0", 32'(layer_clear), 32'b001);
    chk("t1_busy_start", 32'(busy), 32'd1);
    wait_cyc(td - 1);
    chk("t1_busy_pre_done", 32'(busy), 32'd1);
    tick(1);
    chk("t1_done", 32'({done, busy}), 32'b10);
    tick(1);
    chk("t1_done_width", 32'(done), 32'd0);
    q_empty("t1_queue");

    // absolute timing of stage 0 enable window and NEXT
    run3(19, 5, 3, ts, td);
    wait_cyc(ts + 1);
    chk("t2_enable_first", 32'(layer_enable), 32'b001);
    wait_cyc(ts + 21);
    chk("t2_enable_last", 32'(layer_enable), 32'b001);
    wait_cyc(ts + 22);
    chk("t2_next", 32'({layer_clear, layer_enable, busy}), 32'b0000001);
    wait_cyc(td + 2);
    q_empty("t2_queue");

    // stage 1 hangs: watchdog error, then restart from error
    dly[0] = 5;
    dly[1] = 1000;
    dly[2] = 5;
    ts = cyc + 1;
    c1 = ts + 5 + DRN + 2;
    push(0, 0, ts);
    push(0, 1, c1);
    push(2, 1, c1 + TMO + 1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_cyc(c1 + TMO);
    chk("t3_last_run", 32'({error, layer_enable}), 32'b0010);
    tick(1);
    chk("t3_error", 32'({error, busy, layer_enable}), 32'b10000);
    tick(5);
    chk("t3_sticky", 32'(error), 32'd1);
    q_empty("t3_queue");
    run3(3, 3, 3, ts, td);
    chk("t3_restart", 32'({error, layer_clear, layer_idx}), 32'b000100);
    wait_cyc(td + 2);
    q_empty("t3_restart_queue");

    // abort during stage 1 drain
    dly[0] = 4;
    dly[1] = 6;
    dly[2] = 4;
    ts = cyc + 1;
    c1 = ts + 4 + DRN + 2;
    push(0, 0, ts);
    push(0, 1, c1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_cyc(c1 + 7);
    chk("t4_in_drain", 32'({layer_enable, layer_idx}), 32'b01001);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t4_abort_outs", outs(), 32'd0);
    tick(20);
    q_empty("t4_queue");

    // reset during stage 1 run
    ts = cyc + 1;
    c1 = ts + 4 + DRN + 2;
    push(0, 0, ts);
    push(0, 1, c1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_cyc(c1 + 3);
    reset = 1'b1;
    tick(1);
    chk("t4_reset_outs", outs(), 32'd0);
    reset = 1'b0;
    tick(20);
    q_empty("t4r_queue");

    // start during RUN and stray valid[2] during stage 0 are ignored
    force_v = 3'b100;
    run3(10, 10, 10, ts, td);
    wait_cyc(ts + 3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_cyc(ts + 14);
    force_v = '0;
    wait_cyc(td + 2);
    q_empty("t5_queue");

    // valid already high on RUN entry is taken on the first RUN cycle
    force_v = 3'b001;
    run3(1, 2, 3, ts, td);
    dly[0] = 500;
    wait_cyc(ts + 1 + DRN + 2);
    force_v = '0;
    wait_cyc(td + 2);
    q_empty("t5b_queue");

    // back-to-back runs with varied latencies
    for (int r = 0; r < 40; r++) begin
      run3(int'($urandom_range(1, 40)), int'($urandom_range(1, 40)),
           int'($urandom_range(1, 40)), ts, td);
      wait_cyc(td + 1);
    end
    tick(2);
    q_empty("t6_queue");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

endmodule
